// File: rtl/csrng_state_dump_rdr_if.sv
// Status/dump bundle between the CSRNG register file, the internal-state
// dump reader and the CSRNG state database.
// The slave modport is the reader itself. The master modport is the
// surrounding logic: the register file and database plus the enables.
interface csrng_state_dump_rdr_if #(
    parameter int StateId = 4,
    parameter int DATA_W  = 32
);
    // Module enable and software dump permission
    logic                enable_i;
    logic                dump_en_i;

    // Software side (INT_STATE_NUM / INT_STATE_VAL)
    logic                sw_id_wr_i;
    logic [StateId-1:0]  sw_id_i;
    logic                sw_rd_i;
    logic                sw_rd_vld_o;
    logic [DATA_W-1:0]   sw_rd_data_o;
    logic                busy_o;
    logic                err_o;

    // State database side
    logic                db_rd_id_pulse_o;
    logic [StateId-1:0]  db_rd_id_o;
    logic                db_rd_sel_o;
    logic [DATA_W-1:0]   db_rd_val_i;

    modport slave (
        input  enable_i, dump_en_i, sw_id_wr_i, sw_id_i, sw_rd_i, db_rd_val_i,
        output sw_rd_vld_o, sw_rd_data_o, busy_o, err_o,
               db_rd_id_pulse_o, db_rd_id_o, db_rd_sel_o
    );

    modport master (
        output enable_i, dump_en_i, sw_id_wr_i, sw_id_i, sw_rd_i, db_rd_val_i,
        input  sw_rd_vld_o, sw_rd_data_o, busy_o, err_o,
               db_rd_id_pulse_o, db_rd_id_o, db_rd_sel_o
    );
endinterface

// File: rtl/csrng_state_dump_rdr.sv
// CSRNG internal-state dump reader.
// On a software ID write, the block loads the ID into the state database.
// It then captures NumWords consecutive words into a local buffer. After
// that it serves the buffer one word per software read, wrapping after the
// last word. Data passes through unmodified.
module csrng_state_dump_rdr #(
    parameter int NApps    = 4,
    parameter int StateId  = 4,
    parameter int NumWords = 14,
    parameter int DATA_W   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    csrng_state_dump_rdr_if.slave  bus
);

    localparam int                 WcntW    = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [WcntW-1:0]   LastWord = WcntW'(NumWords - 1);
    localparam logic [WcntW-1:0]   SelLast  = WcntW'((NumWords > 1) ? NumWords - 2 : 0);
    localparam logic [StateId:0]   NAppsW   = (StateId + 1)'(NApps);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CAPT,
        SERVE
    } state_e;

    state_e              state_q;
    logic [StateId-1:0]  id_q;
    logic [WcntW-1:0]    wcnt_q;
    logic [WcntW-1:0]    ridx_q;
    logic                vld_q;
    logic                err_q;
    logic                busy_q;
    logic                pulse_q;
    logic                sel_q;
    logic [DATA_W-1:0]   state_buf [NumWords];

    logic                id_ok;

    // Serve index advance. It wraps to word 0 the same way the database
    // read pointer does.
    function automatic logic [WcntW-1:0] wrap_inc(input logic [WcntW-1:0] idx);
        return (idx == LastWord) ? '0 : idx + 1'b1;
    endfunction

    assign id_ok = ({1'b0, bus.sw_id_i} < NAppsW);

    // Control FSM with registered handshake outputs. Enable and dump
    // permission override everything else, and an ID write overrides a read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            wcnt_q  <= '0;
            ridx_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            sel_q   <= 1'b0;
            if (!bus.enable_i) begin
                state_q <= IDLE;
                vld_q   <= 1'b0;
                wcnt_q  <= '0;
                ridx_q  <= '0;
                err_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else if (!bus.dump_en_i) begin
                // Losing permission mid-capture leaves a torn dump: flag it
                if (state_q == LOAD || state_q == CAPT) begin
                    err_q <= 1'b1;
                end
                state_q <= IDLE;
                vld_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else if (bus.sw_id_wr_i) begin
                vld_q <= 1'b0;
                if (id_ok) begin
                    id_q    <= bus.sw_id_i;
                    err_q   <= 1'b0;
                    state_q <= LOAD;
                    busy_q  <= 1'b1;
                    pulse_q <= 1'b1;
                end else begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end
                    LOAD: begin
                        wcnt_q  <= '0;
                        state_q <= CAPT;
                        sel_q   <= (LastWord != '0);
                    end
                    CAPT: begin
                        if (wcnt_q == LastWord) begin
                            state_q <= SERVE;
                            ridx_q  <= '0;
                            vld_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            wcnt_q  <= wcnt_q + 1'b1;
                            sel_q   <= (wcnt_q < SelLast);
                        end
                    end
                    SERVE: begin
                        if (bus.sw_rd_i) begin
                            ridx_q <= wrap_inc(ridx_q);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Capture stage: one database word per CAPT cycle into the buffer.
    // The buffer is never reset because it is only exposed while vld_q is set.
    always_ff @(posedge clk_i) begin
        if (state_q == CAPT) begin
            state_buf[wcnt_q] <= bus.db_rd_val_i;
        end
    end

    // Serve stage: the output word is forced to zero while no complete dump is held
    assign bus.sw_rd_vld_o      = vld_q;
    assign bus.sw_rd_data_o     = vld_q ? state_buf[ridx_q] : '0;
    assign bus.busy_o           = busy_q;
    assign bus.err_o            = err_q;
    assign bus.db_rd_id_pulse_o = pulse_q;
    assign bus.db_rd_id_o       = id_q;
    assign bus.db_rd_sel_o      = sel_q;

endmodule

// File: doc/csrng_state_dump_rdr.md
# csrng_state_dump_rdr

Diagnostic reader for the CSRNG working-state database. It accepts a software instance-ID request and drives the database's status/dump interface (ID pulse, read-select increments). It captures all 32-bit words of the selected instance's internal state into a local buffer, then serves them to the register block one word per software read. It sits between the CSRNG register file (INT_STATE_NUM / INT_STATE_VAL) and the state database.

## Interface
Parameters:
- NApps, 4, number of DRBG instances; IDs >= NApps are invalid
- StateId, 4, instance ID width
- NumWords, 14, 32-bit words per dump (448-bit padded internal state)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- enable_i  in  1  CSRNG module enable
- dump_en_i  in  1  software dump permission (read_int_state enable)
- sw_id_wr_i  in  1  one-cycle pulse: software wrote a new instance ID
- sw_id_i  in  StateId  requested instance ID, valid with sw_id_wr_i
- sw_rd_i  in  1  one-cycle pulse: software consumed the current word
- sw_rd_vld_o  out  1  buffer holds a complete dump
- sw_rd_data_o  out  32  current word; 0 when sw_rd_vld_o=0
- busy_o  out  1  dump capture in progress
- err_o  out  1  sticky error; cleared by next accepted sw_id_wr_i
- db_rd_id_pulse_o  out  1  ID-load pulse to state database
- db_rd_id_o  out  StateId  instance ID to state database
- db_rd_sel_o  out  1  advance database read pointer
- db_rd_val_i  in  32  database word at its current read pointer

All outputs reset to 0.

## Operation
- States: IDLE, LOAD, CAPT, SERVE. Registers: state, id_q, word count wcnt (0..NumWords-1), serve index ridx, buffer buf[NumWords] of 32 bits, err_q.
- Global override, highest priority:
  - enable_i=0 forces IDLE and clears the buffer-valid flag, wcnt, ridx and err_q.
  - dump_en_i=0 also forces IDLE and clears the valid flag. It sets err_q only if the state was LOAD or CAPT.
- IDLE:
  - sw_id_wr_i with sw_id_i < NApps: latch id_q, clear err_q, go to LOAD.
  - sw_id_wr_i with sw_id_i >= NApps: set err_q, stay in IDLE, no database traffic.
- LOAD (1 cycle): db_rd_id_pulse_o=1 and db_rd_id_o=id_q; wcnt:=0; go to CAPT.
- CAPT:
  - Each cycle: buf[wcnt]:=db_rd_val_i.
  - db_rd_sel_o=1 when wcnt<NumWords-1, else 0.
  - wcnt increments each cycle.
  - After capturing word NumWords-1: go to SERVE with ridx:=0.
- SERVE:
  - sw_rd_vld_o=1; sw_rd_data_o=buf[ridx].
  - sw_rd_i increments ridx, wrapping NumWords-1 -> 0, and stays in SERVE. This repeats the dump, matching the database pointer wrap.
- Restart: a valid sw_id_wr_i in LOAD, CAPT or SERVE invalidates the buffer (sw_rd_vld_o drops next cycle), latches the new ID and goes to LOAD. An invalid ID in these states sets err_q and goes to IDLE.
- sw_rd_i when sw_rd_vld_o=0 is ignored.
- sw_id_wr_i and sw_rd_i in the same cycle: the ID write wins and the read is dropped.
- db_rd_id_o holds id_q in all states. db_rd_sel_o and db_rd_id_pulse_o are never asserted in the same cycle.
- Word k corresponds to padded state bits [32k+31:32k]. Word 0 is the low 32 bits of the reseed counter. Word 13 is {30'b0, fips, inst_st}. The block passes data through unmodified.

## Timing
- sw_id_wr_i sampled in cycle N. LOAD in N+1. CAPT in N+2..N+15, capturing word k in cycle N+2+k. db_rd_sel_o=1 in N+2..N+14 and 0 in N+15.
- SERVE from N+16: sw_rd_vld_o=1 at N+16.
- busy_o=1 in N+1..N+15.
- Total latency from request to first data valid: 16 cycles.
- Serving: sw_rd_i in cycle M updates sw_rd_data_o in M+1. Maximum rate is one word per cycle.
- err_o is registered: it asserts the cycle after the offending event.
- rst_i asserted at any point: next cycle everything matches reset values, including mid-capture. Buffer contents are not reset but are never exposed while invalid.

## Test plan
- Normal dump: database model returns 0xA5000000+k for word k; write ID 2 at cycle 0 -> pulse at cycle 1 with id=2, 13 sel pulses, sw_rd_vld_o at cycle 16; 14 reads return 0xA5000000..0xA500000D, and the 15th returns 0xA5000000.
- Invalid ID: write ID 4 with NApps=4 -> err_o=1 the next cycle, no pulse, no sel, sw_rd_vld_o stays 0; then write ID 1 -> err_o clears and the dump completes.
- Abort: deassert dump_en_i at cycle 6 of CAPT -> IDLE, err_o=1, sw_rd_vld_o=0, no further sel pulses; enable_i=0 afterwards -> err_o=0.
- Restart in SERVE: after 5 reads, write ID 3 -> sw_rd_vld_o=0 next cycle, new pulse with id=3, fresh dump; the first read returns word 0 of instance 3.
- Simultaneous sw_id_wr_i and sw_rd_i in SERVE -> restart taken, ridx unchanged until the new dump, which begins at word 0.
- Synchronous reset at cycle 8 of CAPT -> all outputs 0 the next cycle; sw_rd_i pulses afterwards are ignored.
